// File: rtl/sipo_arb_pkg.sv
// Shared types and default sizing for the sipo burst arbiter.
// The FSM state type and the default producer/line geometry live here.
package sipo_arb_pkg;

    localparam int DEF_NUM_REQ        = 4;
    localparam int DEF_SIZE_OF_INPUT  = 64;
    localparam int DEF_SIZE_OF_BUFFER = 8;

    // Source-ID width for the default producer count.
    localparam int ID_W = $clog2(DEF_NUM_REQ);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        FILL      = 2'd1,
        FULL_WAIT = 2'd2,
        DRAIN     = 2'd3
    } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: returns the first requester at or after ptr,
// wrapping back to index 0 when nothing at or above ptr is requesting.
module rr_arbiter
    import sipo_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int ID_W_P  = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W_P-1:0]  ptr,
    output logic [ID_W_P-1:0]  gnt_id,
    output logic               gnt_valid
);

    logic [NUM_REQ-1:0] ptr_mask;
    logic [NUM_REQ-1:0] hi_req;
    logic               hi_any;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_mask
            assign ptr_mask[gi] = (ID_W_P'(gi) >= ptr);
        end
    endgenerate

    assign hi_req = req & ptr_mask;
    assign hi_any = |hi_req;

    // Scanning downward leaves the lowest qualifying index in gnt_id.
    always_comb begin
        gnt_id    = '0;
        gnt_valid = |req;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (hi_any ? hi_req[i] : req[i]) begin
                gnt_id = ID_W_P'(i);
            end
        end
    end

endmodule

// File: rtl/sipo_burst_arbiter.sv
// Shares one sipo line buffer among NUM_REQ producers: grants a full-line burst
// round-robin, strobes the buffer, and presents each finished line with its source ID.
module sipo_burst_arbiter
    import sipo_arb_pkg::*;
#(
    parameter int NUM_REQ        = DEF_NUM_REQ,
    parameter int SIZE_OF_INPUT  = DEF_SIZE_OF_INPUT,
    parameter int SIZE_OF_BUFFER = DEF_SIZE_OF_BUFFER
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic [NUM_REQ-1:0]                 req_valid_i,
    input  logic [NUM_REQ*SIZE_OF_INPUT-1:0]   req_data_i,
    output logic [NUM_REQ-1:0]                 req_ready_o,
    output logic                               sipo_wr_en_o,
    output logic                               sipo_rd_en_o,
    output logic [SIZE_OF_INPUT-1:0]           sipo_data_o,
    input  logic                               sipo_is_full_i,
    output logic                               line_valid_o,
    input  logic                               line_ready_i,
    output logic [$clog2(NUM_REQ)-1:0]         line_src_o,
    output logic                               err_o
);

    localparam int SRC_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(SIZE_OF_BUFFER + 1);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(SIZE_OF_BUFFER - 1);
    localparam logic [CNT_W-1:0] FULL_BEAT = CNT_W'(SIZE_OF_BUFFER);
    localparam logic [SRC_W-1:0] LAST_ID   = SRC_W'(NUM_REQ - 1);

    arb_state_e         state_reg, state_next;
    logic [SRC_W-1:0]   grant_id_reg, grant_id_next;
    logic [SRC_W-1:0]   rr_ptr_reg, rr_ptr_next;
    logic [SRC_W-1:0]   line_src_reg, line_src_next;
    logic [CNT_W-1:0]   beat_cnt_reg, beat_cnt_next;
    logic               line_valid_reg, line_valid_next;
    logic               err_reg, err_next;

    logic [SRC_W-1:0]   arb_gnt_id;
    logic               arb_gnt_valid;
    logic [SIZE_OF_INPUT-1:0] req_word [NUM_REQ];
    logic [NUM_REQ-1:0] ready_vec;
    logic               in_fill;
    logic               accept;
    logic               line_done;
    logic               slot_free;

    assign in_fill   = (state_reg == FILL);
    assign accept    = in_fill && req_valid_i[grant_id_reg];
    assign line_done = accept && (beat_cnt_reg == LAST_BEAT);
    // sipo.data_o may be overwritten once the current line is gone or leaving now.
    assign slot_free = !line_valid_reg || line_ready_i;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_port
            assign req_word[gi]  = req_data_i[gi*SIZE_OF_INPUT +: SIZE_OF_INPUT];
            assign ready_vec[gi] = in_fill && (grant_id_reg == SRC_W'(gi));
        end
    endgenerate

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W_P  (SRC_W)
    ) u_rr_arbiter (
        .req       (req_valid_i),
        .ptr       (rr_ptr_reg),
        .gnt_id    (arb_gnt_id),
        .gnt_valid (arb_gnt_valid)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:      if (arb_gnt_valid) state_next = FILL;
            FILL:      if (line_done) state_next = slot_free ? DRAIN : FULL_WAIT;
            FULL_WAIT: if (slot_free) state_next = DRAIN;
            DRAIN:     state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    always_comb begin
        req_ready_o  = ready_vec;
        sipo_wr_en_o = accept;
        sipo_rd_en_o = (state_reg == DRAIN);
        sipo_data_o  = in_fill ? req_word[grant_id_reg] : '0;
    end

    always_comb begin
        grant_id_next   = grant_id_reg;
        rr_ptr_next     = rr_ptr_reg;
        beat_cnt_next   = beat_cnt_reg;
        line_valid_next = line_valid_reg;
        line_src_next   = line_src_reg;
        err_next        = err_reg;

        if (state_reg == IDLE && arb_gnt_valid) begin
            grant_id_next = arb_gnt_id;
        end
        if (accept) begin
            beat_cnt_next = beat_cnt_reg + 1'b1;
        end
        if (line_valid_reg && line_ready_i) begin
            line_valid_next = 1'b0;
        end
        // A drain in the same cycle as a handshake re-arms the slot with the new line.
        if (state_reg == DRAIN) begin
            beat_cnt_next   = '0;
            rr_ptr_next     = (grant_id_reg == LAST_ID) ? '0 : grant_id_reg + 1'b1;
            line_valid_next = 1'b1;
            line_src_next   = grant_id_reg;
        end
        if ((state_reg == FULL_WAIT || state_reg == DRAIN) &&
            (sipo_is_full_i != (beat_cnt_reg == FULL_BEAT))) begin
            err_next = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            grant_id_reg   <= '0;
            rr_ptr_reg     <= '0;
            beat_cnt_reg   <= '0;
            line_valid_reg <= 1'b0;
            line_src_reg   <= '0;
            err_reg        <= 1'b0;
        end else begin
            grant_id_reg   <= grant_id_next;
            rr_ptr_reg     <= rr_ptr_next;
            beat_cnt_reg   <= beat_cnt_next;
            line_valid_reg <= line_valid_next;
            line_src_reg   <= line_src_next;
            err_reg        <= err_next;
        end
    end

    assign line_valid_o = line_valid_reg;
    assign line_src_o   = line_src_reg;
    assign err_o        = err_reg;

endmodule

// File: tb/tb_sipo_burst_arbiter.sv
// Bench for sipo_burst_arbiter: directed scenarios plus random traffic against a
// cycle-level behavioural model of the arbitration rules and a small sipo stand-in.
module tb_sipo_burst_arbiter;

    localparam int NR = 4;
    localparam int W  = 64;
    localparam int N  = 8;
    localparam int PH_IDLE = 0, PH_FILL = 1, PH_WAIT = 2, PH_DRAIN = 3;

    logic              clk_i = 1'b0;
    logic              rst_i = 1'b1;
    logic [NR-1:0]     req_valid_i = '0;
    logic [NR*W-1:0]   req_data_i = '0;
    logic [NR-1:0]     req_ready_o;
    logic              sipo_wr_en_o, sipo_rd_en_o;
    logic [W-1:0]      sipo_data_o;
    logic              sipo_is_full_i = 1'b0;
    logic              line_valid_o;
    logic              line_ready_i = 1'b0;
    logic [1:0]        line_src_o;
    logic              err_o;

    sipo_burst_arbiter #(.NUM_REQ(NR), .SIZE_OF_INPUT(W), .SIZE_OF_BUFFER(N)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .req_valid_i    (req_valid_i),
        .req_data_i     (req_data_i),
        .req_ready_o    (req_ready_o),
        .sipo_wr_en_o   (sipo_wr_en_o),
        .sipo_rd_en_o   (sipo_rd_en_o),
        .sipo_data_o    (sipo_data_o),
        .sipo_is_full_i (sipo_is_full_i),
        .line_valid_o   (line_valid_o),
        .line_ready_i   (line_ready_i),
        .line_src_o     (line_src_o),
        .err_o          (err_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int failures = 0;

    // reference model state
    int m_phase, m_gid, m_ptr, m_cnt, m_src;
    bit m_lv, m_err;
    logic [W-1:0]   m_line[$];
    logic [N*W-1:0] m_presented;

    // sipo stand-in fed by the DUT strobes
    logic [W-1:0]   sq[$];
    logic [N*W-1:0] sipo_line;

    int  pseq[NR];
    bit  force_empty = 1'b0;
    int  cyc = 0;
    int  hs_src[$];
    int  hs_cyc[$];
    logic [N*W-1:0] hs_line[$];

    task automatic chk(input string tag, input logic [N*W-1:0] obs, input logic [N*W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [N*W-1:0] pack_q(input logic [W-1:0] q[$]);
        logic [N*W-1:0] v = '0;
        for (int i = 0; i < q.size() && i < N; i++) v[i*W +: W] = q[i];
        return v;
    endfunction

    task automatic model_reset();
        m_phase = PH_IDLE; m_gid = 0; m_ptr = 0; m_cnt = 0; m_src = 0;
        m_lv = 0; m_err = 0; m_presented = '0;
        m_line.delete(); sq.delete(); sipo_line = '0;
    endtask

    task automatic clear_hs();
        hs_src.delete(); hs_cyc.delete(); hs_line.delete();
    endtask

    // One clock: drive derived inputs, compare at negedge, advance model at posedge.
    task automatic step();
        logic [NR-1:0] exp_ready;
        logic [W-1:0]  exp_data;
        bit exp_wr, free, found, d_wr, d_rd;
        logic [W-1:0] d_data;
        int n_phase, n_gid, n_ptr, n_cnt, n_src, idx;
        bit n_lv, n_err;

        for (int k = 0; k < NR; k++) req_data_i[k*W +: W] = {32'(k), 32'(pseq[k] + 1)};
        sipo_is_full_i = force_empty ? 1'b0 : (sq.size() == N);
        @(negedge clk_i);

        exp_ready = '0;
        exp_data  = '0;
        exp_wr    = 1'b0;
        if (m_phase == PH_FILL) begin
            exp_ready[m_gid] = 1'b1;
            exp_data = req_data_i[m_gid*W +: W];
            exp_wr   = req_valid_i[m_gid];
        end
        chk("req_ready", req_ready_o, exp_ready);
        chk("sipo_wr_en", sipo_wr_en_o, exp_wr);
        chk("sipo_rd_en", sipo_rd_en_o, m_phase == PH_DRAIN);
        chk("sipo_data", sipo_data_o, exp_data);
        chk("line_valid", line_valid_o, m_lv);
        chk("line_src", line_src_o, m_src);
        chk("err", err_o, m_err);
        chk("strobe_excl", sipo_wr_en_o & sipo_rd_en_o, 0);
        if (m_lv && line_ready_i) chk("line_data", sipo_line, m_presented);
        if (line_valid_o && line_ready_i) begin
            hs_src.push_back(int'(line_src_o));
            hs_cyc.push_back(cyc);
            hs_line.push_back(sipo_line);
        end

        free = !m_lv || line_ready_i;
        n_phase = m_phase; n_gid = m_gid; n_ptr = m_ptr; n_cnt = m_cnt;
        n_src = m_src; n_lv = m_lv; n_err = m_err;
        if ((m_phase == PH_WAIT || m_phase == PH_DRAIN) && (sipo_is_full_i != (m_cnt == N)))
            n_err = 1'b1;
        if (m_lv && line_ready_i) n_lv = 1'b0;
        case (m_phase)
            PH_IDLE: begin
                found = 1'b0;
                for (int k = 0; k < NR; k++) begin
                    idx = (m_ptr + k) % NR;
                    if (!found && req_valid_i[idx]) begin
                        found = 1'b1; n_gid = idx; n_phase = PH_FILL;
                    end
                end
            end
            PH_FILL: if (req_valid_i[m_gid]) begin
                m_line.push_back(req_data_i[m_gid*W +: W]);
                n_cnt = m_cnt + 1;
                if (n_cnt == N) n_phase = free ? PH_DRAIN : PH_WAIT;
            end
            PH_WAIT: if (free) n_phase = PH_DRAIN;
            default: begin
                n_phase = PH_IDLE; n_cnt = 0; n_ptr = (m_gid + 1) % NR;
                n_lv = 1'b1; n_src = m_gid;
                m_presented = pack_q(m_line);
                m_line.delete();
            end
        endcase

        d_wr = sipo_wr_en_o; d_rd = sipo_rd_en_o; d_data = sipo_data_o;
        @(posedge clk_i);
        if (d_rd) begin sipo_line = pack_q(sq); sq.delete(); end
        else if (d_wr) sq.push_back(d_data);
        if (m_phase == PH_FILL && req_valid_i[m_gid]) pseq[m_gid]++;
        m_phase = n_phase; m_gid = n_gid; m_ptr = n_ptr; m_cnt = n_cnt;
        m_src = n_src; m_lv = n_lv; m_err = n_err;
        cyc++;
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Asserted away from the clock edge; outputs must drop immediately.
    task automatic do_reset();
        req_valid_i = '0;
        rst_i = 1'b1;
        #2;
        chk("rst_req_ready", req_ready_o, 0);
        chk("rst_wr_en", sipo_wr_en_o, 0);
        chk("rst_rd_en", sipo_rd_en_o, 0);
        chk("rst_data", sipo_data_o, 0);
        chk("rst_line_valid", line_valid_o, 0);
        chk("rst_line_src", line_src_o, 0);
        chk("rst_err", err_o, 0);
        rst_i = 1'b0;
        model_reset();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        logic [N*W-1:0] exp_line;
        int base;

        for (int k = 0; k < NR; k++) pseq[k] = 0;
        model_reset();
        @(posedge clk_i);
        #1;
        do_reset();

        // single producer 0 streams 0x1..0x8
        clear_hs();
        req_valid_i = 4'b0001; line_ready_i = 1'b1; cyc = 0;
        run(14);
        for (int i = 0; i < N; i++) exp_line[i*W +: W] = 64'(i + 1);
        chk("A_hs_count", hs_src.size() >= 1, 1);
        if (hs_src.size() >= 1) begin
            chk("A_src", hs_src[0], 0);
            chk("A_line", hs_line[0], exp_line);
            chk("A_latency", hs_cyc[0], 10);
        end

        // all four requesting, consumer always ready
        do_reset();
        clear_hs();
        req_valid_i = 4'b1111; line_ready_i = 1'b1;
        run(55);
        chk("B_hs_count", hs_src.size() >= 5, 1);
        for (int i = 0; i < 5 && i < hs_src.size(); i++) begin
            chk("B_src_order", hs_src[i], i % NR);
            if (i > 0) chk("B_period", hs_cyc[i] - hs_cyc[i-1], N + 2);
        end

        // consumer stalls for 20 cycles, then resumes
        line_ready_i = 1'b0;
        run(20);
        chk("C_hold_valid", line_valid_o, 1);
        line_ready_i = 1'b1;
        run(30);

        // producer 2 pauses mid-burst while 1 and 3 request
        do_reset();
        clear_hs();
        req_valid_i = 4'b0100;
        run(4);
        req_valid_i = 4'b1010;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("D_grant_held", req_ready_o, 4'b0100);
        end
        req_valid_i = 4'b1110;
        run(10);
        chk("D_hs_count", hs_src.size() >= 1, 1);
        if (hs_src.size() >= 1) chk("D_src", hs_src[0], 2);

        // reset after five words of a burst
        do_reset();
        req_valid_i = 4'b0001;
        run(6);
        do_reset();
        clear_hs();
        base = pseq[0];
        req_valid_i = 4'b0001;
        run(12);
        for (int i = 0; i < N; i++) exp_line[i*W +: W] = 64'(base + i + 1);
        chk("E_hs_count", hs_src.size() >= 1, 1);
        if (hs_src.size() >= 1) begin
            chk("E_src", hs_src[0], 0);
            chk("E_line", hs_line[0], exp_line);
        end

        // full flag disagrees with the beat count -> sticky error
        do_reset();
        req_valid_i = 4'b0001; force_empty = 1'b1;
        run(12);
        chk("F_err_set", err_o, 1);
        force_empty = 1'b0; req_valid_i = '0;
        run(10);
        chk("F_err_sticky", err_o, 1);
        do_reset();

        // random traffic
        for (int i = 0; i < 400; i++) begin
            req_valid_i  = NR'($urandom);
            line_ready_i = ($urandom_range(0, 3) != 0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sipo_burst_arbiter.md
# sipo_burst_arbiter

Controller that shares one `sipo` line-packing buffer (`SIZE_OF_INPUT`-bit words packed into `SIZE_OF_BUFFER`-word lines) between `NUM_REQ` streaming producers.
- It grants the buffer round-robin to one producer for a full line burst.
- It drives the buffer's write and read strobes.
- It presents each completed line to a single downstream consumer with a valid/ready handshake and the source ID.
- It sits between the feature-extraction producers and the line consumer; line data goes straight from `sipo.data_o` to the consumer, and this block carries only control, routing and source tagging.

## Interface
- `NUM_REQ`, 4, number of producers (2..16)
- `SIZE_OF_INPUT`, 64, producer word width
- `SIZE_OF_BUFFER`, 8, words per line (1..15, matching the `sipo` 4-bit pointer)
- `clk_i`  in  1  clock
- `rst_i`  in  1  asynchronous, active-high reset. The same reset, inverted, drives the `sipo` reset.
- `req_valid_i`  in  NUM_REQ  per-producer word valid
- `req_data_i`  in  NUM_REQ*SIZE_OF_INPUT  producer words; producer k occupies bits `[k*SIZE_OF_INPUT +: SIZE_OF_INPUT]`
- `req_ready_o`  out  NUM_REQ  per-producer word accept
- `sipo_wr_en_o`  out  1  `sipo` write strobe
- `sipo_rd_en_o`  out  1  `sipo` read strobe
- `sipo_data_o`  out  SIZE_OF_INPUT  word muxed from the granted producer
- `sipo_is_full_i`  in  1  `sipo` full flag
- `line_valid_o`  out  1  `sipo.data_o` holds an unconsumed line
- `line_ready_i`  in  1  consumer accepts the line
- `line_src_o`  out  $clog2(NUM_REQ)  producer ID of the presented line
- `err_o`  out  1  sticky; set on beat-count/`is_full` mismatch

## Operation
- FSM states:
  - `IDLE`: no grant.
  - `FILL`: grant held, accepting words.
  - `FULL_WAIT`: line complete, output slot occupied.
  - `DRAIN`: `sipo_rd_en_o` high for one cycle.
- `IDLE`: if any `req_valid_i` bit is set, grant the first requester at or after `rr_ptr` (round-robin, wrapping at `NUM_REQ`-1 → 0). Register `grant_id` and go to `FILL`.
- `FILL`:
  - `req_ready_o[grant_id]` = 1; all other ready bits are 0.
  - `sipo_wr_en_o` = `req_valid_i[grant_id]`.
  - `sipo_data_o` = the granted producer's word.
  - Each accepted word increments `beat_cnt` (width `$clog2(SIZE_OF_BUFFER+1)`).
  - When the `SIZE_OF_BUFFER`-th word is accepted, go to `DRAIN` if the output slot will be free next cycle, otherwise go to `FULL_WAIT`.
  - A granted producer that drops valid mid-burst stalls `FILL`; the grant is never revoked.
- Output slot free means `!line_valid_o || line_ready_i`.
- `FULL_WAIT`: go to `DRAIN` once the slot is free.
- `DRAIN`:
  - `sipo_rd_en_o` = 1 and `sipo_wr_en_o` = 0. The two strobes are never asserted together.
  - Latch `line_src_o` = `grant_id` and set `line_valid_o` for the next cycle.
  - Clear `beat_cnt` and set `rr_ptr` = `grant_id`+1 (wrapping).
  - Go to `IDLE`.
- `line_valid_o` clears on `line_valid_o && line_ready_i`, unless a `DRAIN` occurs in the same cycle, in which case it stays 1 with the new source.
- A new line's `FILL` may overlap presentation of the previous line, because `sipo.data_o` changes only on `sipo_rd_en_o`.
- `err_o` is set when `sipo_is_full_i` differs from (`beat_cnt == SIZE_OF_BUFFER`) while in `FULL_WAIT` or `DRAIN`. It is cleared only by reset.

## Timing
- Reset values:
  - state `IDLE`, `rr_ptr` 0, `grant_id` 0, `beat_cnt` 0
  - `req_ready_o` 0, `sipo_wr_en_o` 0, `sipo_rd_en_o` 0, `sipo_data_o` 0
  - `line_valid_o` 0, `line_src_o` 0, `err_o` 0
- Reset asserted mid-burst discards the partial line; the `sipo` is reset by the same reset.
- `req_ready_o` is registered from state and `grant_id`. There is no combinational path from `req_valid_i` to `req_ready_o`.
- Grant latency: request seen in `IDLE` at cycle t → `req_ready_o` high at t+1.
- Line latency: last word accepted at cycle t → `DRAIN` at t+1 (free slot) → `line_valid_o` = 1 at t+2.
- Minimum line period is `SIZE_OF_BUFFER`+2 cycles: `IDLE` + N×`FILL` + `DRAIN`.

## Structure
- Shared package `sipo_arb_pkg`:
  - FSM state enum `{IDLE, FILL, FULL_WAIT, DRAIN}`
  - default-parameter constants
  - `ID_W = $clog2(NUM_REQ)`
- Sub-module `rr_arbiter`: combinational, with `req`, `ptr` → `gnt_id`, `gnt_valid`.
- FSM, counters, word mux and output slot live in the top level.
- Integration instantiates `sipo` alongside this block (`rst_i` inverted to `sipo`'s active-low reset), not inside it.

## Test plan
- Single producer: 0 streams 8 words 0x1..0x8 → one `sipo_rd_en_o` pulse; at t+2 `line_valid_o`=1, `line_src_o`=0, line = {0x8,…,0x1}.
- All four requesting continuously, `line_ready_i`=1 → `line_src_o` sequence 0,1,2,3,0; each line period 10 cycles.
- Consumer holds `line_ready_i`=0 for 20 cycles:
  - the second line fills, then waits in `FULL_WAIT` with no `sipo_rd_en_o`;
  - on ready, the same-cycle handshake plus `DRAIN` keeps `line_valid_o`=1 and `line_src_o` switches to the new source.
- Granted producer 2 drops valid after 3 words for 5 cycles while 1 and 3 request → no re-grant; the line completes with `line_src_o`=2.
- `rst_i` pulse after 5 words of a burst → all outputs at reset values; the next full line from producer 0 is correct.
- Force `sipo_is_full_i`=0 at the end of a burst → `err_o`=1, and it stays 1 until reset.
